// File: rtl/alu_issue.sv
// Single-issue MIPS ALU front end: latches one instruction, decodes it, drives an
// external combinational ALU and holds the write-back result until it is consumed.
module alu_issue #(
  parameter logic ERR_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [2:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_dest,
  output logic        out_err,
  output logic [1:0]  state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
  // in_ready is 1 only in IDLE, out_valid is 1 only in RESP; the other side's
  // valid/ready is ignored in every other state.

  typedef enum logic [1:0] {IDLE = 2'd0, DECODE = 2'd1, EXEC = 2'd2, RESP = 2'd3} state_t;

  state_t      state_q, state_d;
  logic        dec_phase_q;
  logic [5:0]  opcode_q;
  logic [20:0] low_q;
  logic [31:0] rs_q, rt_q;

  logic        dec_legal, dec_legal_q;
  logic [2:0]  dec_op, dec_op_q;
  logic [31:0] dec_b, dec_b_q;
  logic [4:0]  dec_dest, dec_dest_q;

  logic [5:0]  funct;
  logic [15:0] imm;

  assign funct = low_q[5:0];
  assign imm   = low_q[15:0];

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = 3'd0;
    dec_b     = rt_q;
    dec_dest  = low_q[15:11];
    case (opcode_q)
      6'h00: begin
        case (funct)
          6'h24: begin dec_legal = 1'b1; dec_op = 3'd0; end
          6'h25: begin dec_legal = 1'b1; dec_op = 3'd1; end
          6'h21: begin dec_legal = 1'b1; dec_op = 3'd2; end
          6'h23: begin dec_legal = 1'b1; dec_op = 3'd3; end
          6'h2B: begin dec_legal = 1'b1; dec_op = 3'd4; end
          default: dec_legal = 1'b0;
        endcase
      end
      6'h0C: begin
        dec_legal = 1'b1; dec_op = 3'd0;
        dec_b = {16'h0000, imm}; dec_dest = low_q[20:16];
      end
      6'h0D: begin
        dec_legal = 1'b1; dec_op = 3'd1;
        dec_b = {16'h0000, imm}; dec_dest = low_q[20:16];
      end
      6'h09: begin
        dec_legal = 1'b1; dec_op = 3'd2;
        dec_b = {{16{imm[15]}}, imm}; dec_dest = low_q[20:16];
      end
      6'h0B: begin
        dec_legal = 1'b1; dec_op = 3'd4;
        dec_b = {{16{imm[15]}}, imm}; dec_dest = low_q[20:16];
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Decode spans two cycles: phase 0 registers the decoded fields, phase 1 commits them.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = DECODE;
      DECODE:  if (dec_phase_q) state_d = dec_legal_q ? EXEC : RESP;
      EXEC:    state_d = RESP;
      RESP:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == RESP);
  assign state_dbg = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dec_phase_q <= 1'b0;
      opcode_q    <= 6'd0;
      low_q       <= 21'd0;
      rs_q        <= 32'd0;
      rt_q        <= 32'd0;
      dec_legal_q <= 1'b0;
      dec_op_q    <= 3'd0;
      dec_b_q     <= 32'd0;
      dec_dest_q  <= 5'd0;
      alu_op      <= 3'd0;
      alu_a       <= 32'd0;
      alu_b       <= 32'd0;
      out_data    <= 32'd0;
      out_dest    <= 5'd0;
      out_err     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          dec_phase_q <= 1'b0;
          if (in_valid) begin
            opcode_q <= instr[31:26];
            low_q    <= instr[20:0];
            rs_q     <= rs_data;
            rt_q     <= rt_data;
          end
        end
        DECODE: begin
          dec_phase_q <= ~dec_phase_q;
          if (!dec_phase_q) begin
            dec_legal_q <= dec_legal;
            dec_op_q    <= dec_op;
            dec_b_q     <= dec_b;
            dec_dest_q  <= dec_dest;
          end else if (dec_legal_q) begin
            alu_op   <= dec_op_q;
            alu_a    <= rs_q;
            alu_b    <= dec_b_q;
            out_dest <= dec_dest_q;
            out_err  <= 1'b0;
          end else begin
            out_data <= 32'd0;
            out_dest <= 5'd0;
            out_err  <= ERR_ILLEGAL;
          end
        end
        EXEC: begin
          // Writes to register 0 are architecturally discarded.
          out_data <= (out_dest == 5'd0) ? 32'd0 : alu_result;
          out_err  <= 1'b0;
        end
        default: dec_phase_q <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: two instances (ERR_ILLEGAL=1 and 0) run in lockstep
// against a behavioural ALU, with hand-computed expected write-back values.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] instr, rs_data, rt_data;
  logic        out_ready;

  logic        in_ready, out_valid, out_err;
  logic [2:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result, out_data;
  logic [4:0]  out_dest;
  logic [1:0]  state_dbg;

  logic        in_ready0, out_valid0, out_err0;
  logic [2:0]  alu_op0;
  logic [31:0] alu_a0, alu_b0, alu_result0, out_data0;
  logic [4:0]  out_dest0;
  logic [1:0]  state_dbg0;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [31:0] exp_q[$];
  logic [2:0]  last_op;
  logic [31:0] last_b;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd3: return a - b;
      3'd4: return {31'd0, (a < b)};
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result  = alu_f(alu_op, alu_a, alu_b);
  assign alu_result0 = alu_f(alu_op0, alu_a0, alu_b0);

  alu_issue dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_dest(out_dest), .out_err(out_err), .state_dbg(state_dbg)
  );

  alu_issue #(.ERR_ILLEGAL(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .alu_op(alu_op0), .alu_a(alu_a0), .alu_b(alu_b0), .alu_result(alu_result0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_dest(out_dest0), .out_err(out_err0), .state_dbg(state_dbg0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_out_err"}, {31'd0, out_err}, 32'd0);
    check({tag, "_out_data"}, out_data, 32'd0);
    check({tag, "_out_dest"}, {27'd0, out_dest}, 32'd0);
    check({tag, "_alu_op"}, {29'd0, alu_op}, 32'd0);
    check({tag, "_alu_a"}, alu_a, 32'd0);
    check({tag, "_alu_b"}, alu_b, 32'd0);
  endtask

  // Issue one instruction and follow it to its response. legal selects which
  // ALU-operand expectations apply; noisy keeps in_valid high with junk in flight.
  task automatic run(input string tag, input logic [31:0] i, input logic [31:0] rs,
                     input logic [31:0] rt, input logic legal, input logic [2:0] e_op,
                     input logic [31:0] e_b, input logic [31:0] e_data, input logic [4:0] e_dest,
                     input logic e_err, input int hold, input logic noisy);
    int lat;
    logic [31:0] exp_data;
    exp_q.push_back(e_data);
    @(negedge clk);
    instr = i; rs_data = rs; rt_data = rt; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = noisy;
    instr = $urandom; rs_data = $urandom; rt_data = $urandom;
    lat = 0;
    while (!out_valid && lat < 12) begin
      check({tag, "_busy_in_ready"}, {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, legal ? 32'd3 : 32'd2);
    if (out_valid) begin
      exp_data = exp_q.pop_front();
      if (legal) begin
        last_op = e_op;
        last_b  = e_b;
      end
      check({tag, "_alu_op"}, {29'd0, alu_op}, {29'd0, last_op});
      check({tag, "_alu_b"}, alu_b, last_b);
      check({tag, "_alu_a"}, alu_a, legal ? rs : alu_a0);
      for (int c = 0; c <= hold; c++) begin
        check({tag, "_data"}, out_data, exp_data);
        check({tag, "_dest"}, {27'd0, out_dest}, {27'd0, e_dest});
        check({tag, "_err"}, {31'd0, out_err}, {31'd0, e_err});
        check({tag, "_in_ready_resp"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_valid_resp"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_p0_valid"}, {31'd0, out_valid0}, 32'd1);
        check({tag, "_p0_err"}, {31'd0, out_err0}, 32'd0);
        check({tag, "_p0_data"}, out_data0, exp_data);
        if (c < hold) begin
          @(posedge clk); #1;
        end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_released_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_released_in_ready"}, {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      void'(exp_q.pop_front());
      in_valid = 1'b0;
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    instr = 32'd0; rs_data = 32'd0; rt_data = 32'd0;
    last_op = 3'd0; last_b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    reset = 1'b0;

    //   tag       instr         rs            rt            legal op    alu_b         data          dest err hold noisy
    run("addu",  32'h00851021, 32'hFFFFFFFF, 32'h00000002, 1, 3'd2, 32'h00000002, 32'h00000001, 5'd2, 0, 0, 0);
    run("addiu", 32'h2402FFFF, 32'h00000005, 32'h0BADBEEF, 1, 3'd2, 32'hFFFFFFFF, 32'h00000004, 5'd2, 0, 0, 0);
    run("andi",  32'h3003FFFF, 32'h12345678, 32'h00000000, 1, 3'd0, 32'h0000FFFF, 32'h00005678, 5'd3, 0, 0, 1);
    run("sltiu", 32'h2C040001, 32'h00000000, 32'h00000000, 1, 3'd4, 32'h00000001, 32'h00000001, 5'd4, 0, 0, 0);
    run("subu",  32'h00852823, 32'h00000003, 32'h00000005, 1, 3'd3, 32'h00000005, 32'hFFFFFFFE, 5'd5, 0, 5, 0);
    run("jr",    32'h00000008, 32'h11111111, 32'h22222222, 0, 3'd0, 32'h0,        32'h00000000, 5'd0, 1, 2, 0);
    run("ori",   32'h340600F0, 32'h0F00000F, 32'h00000000, 1, 3'd1, 32'h000000F0, 32'h0F0000FF, 5'd6, 0, 0, 0);
    run("or",    32'h00853825, 32'h000000A0, 32'h0000000A, 1, 3'd1, 32'h0000000A, 32'h000000AA, 5'd7, 0, 0, 0);
    run("and",   32'h00854024, 32'hFF00FF00, 32'h0FF00FF0, 1, 3'd0, 32'h0FF00FF0, 32'h0F000F00, 5'd8, 0, 0, 0);
    run("sltu",  32'h0085482B, 32'h00000001, 32'hFFFFFFFF, 1, 3'd4, 32'hFFFFFFFF, 32'h00000001, 5'd9, 0, 0, 0);
    run("rd0",   32'h00850021, 32'h00000001, 32'h00000001, 1, 3'd2, 32'h00000001, 32'h00000000, 5'd0, 0, 0, 0);
    run("lw",    32'h8C820000, 32'h00000010, 32'h00000020, 0, 3'd0, 32'h0,        32'h00000000, 5'd0, 1, 0, 1);
    run("add",   32'h00851020, 32'h00000004, 32'h00000004, 0, 3'd0, 32'h0,        32'h00000000, 5'd0, 1, 0, 0);

    // Reset while the instruction is in EXEC discards it.
    @(negedge clk);
    instr = 32'h00851021; rs_data = 32'h00000007; rt_data = 32'h00000008; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (state_dbg != 2'd2 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_exec", {30'd0, state_dbg}, 32'd2);
    #1 reset = 1'b1;
    #1;
    check_reset_state("exec_reset");
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    check("no_resp_after_reset", n, 32'd0);
    last_op = 3'd0; last_b = 32'd0;
    run("post_reset", 32'h00851021, 32'h00000010, 32'h00000020, 1, 3'd2, 32'h00000020, 32'h00000030, 5'd2, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
